// File: rtl/gf163_digit_mul.sv
// Digit-serial GF(2^163) multiplier, f(x)=x^163+x^7+x^6+x^3+1, two 82-bit Horner digits of B (MSB digit first).
// Optional define GF163_MUL_PERF_EN adds the mul_count output (completed-handshake counter).
module gf163_digit_mul (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [162:0] a,
    input  logic [162:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [162:0] p
`ifdef GF163_MUL_PERF_EN
    ,
    output logic [31:0]  mul_count
`endif
);

    localparam int unsigned M  = 163;
    localparam int unsigned D  = 82;
    localparam int unsigned W  = M + D;
    localparam int unsigned PW = W - 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t         r_state;
    logic [M-1:0]   r_a;
    logic [M-1:0]   r_b;
    logic [M-1:0]   r_c;
    logic [M-1:0]   r_p;
    logic           r_dig_cnt;
    logic           r_out_valid;

    logic [D-1:0]   w_digit;
    logic [PW-1:0]  w_prod;
    logic [W-1:0]   w_word;
    logic [M-1:0]   w_red;

    // Carry-less product of the full A operand with one B digit.
    function automatic logic [PW-1:0] clmul(input logic [M-1:0] x, input logic [D-1:0] d);
        logic [PW-1:0] acc;
        acc = '0;
        for (int j = 0; j < int'(D); j++) begin
            if (d[j]) acc = acc ^ (PW'(x) << j);
        end
        return acc;
    endfunction

    // Reduction of a 245-bit word: the folded high part ends below bit 89, so one fold suffices.
    function automatic logic [M-1:0] reduce245(input logic [W-1:0] w);
        logic [M-1:0] hi;
        hi = M'(w[W-1:M]);
        return w[M-1:0] ^ hi ^ (hi << 3) ^ (hi << 6) ^ (hi << 7);
    endfunction

    always_comb begin
        w_digit = r_dig_cnt ? r_b[D-1:0] : D'(r_b[M-1:D]);
        w_prod  = clmul(r_a, w_digit);
        w_word  = {r_c, {D{1'b0}}} ^ W'(w_prod);
        w_red   = reduce245(w_word);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_p         <= '0;
            r_dig_cnt   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_c       <= '0;
                        r_dig_cnt <= 1'b0;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_c       <= w_red;
                    r_dig_cnt <= 1'b1;
                    if (r_dig_cnt) begin
                        r_p         <= w_red;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef GF163_MUL_PERF_EN
    logic [31:0] r_mul_count;

    // Counts accepted products; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_mul_count <= r_mul_count + 32'd1;
        end
    end

    assign mul_count = r_mul_count;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign p         = r_p;

endmodule
